// File: rtl/ex_mem_pipe_if.sv
// ex_mem_pipe_if: bundles the EX->MEM handshake, payload, occupancy and
// forwarding signals of the EX/MEM pipeline register.
//   slave  : the pipeline register itself. It receives flush, in_valid,
//            ex_* and out_ready. It drives in_ready, out_valid, mem_*,
//            occupancy and fwd_*.
//   master : the surrounding pipeline (EX, MEM and ID stages, or a bench).
interface ex_mem_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int WE_W    = 4,
  parameter int ALUOP_W = 8
) ();
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [RADDR_W-1:0] ex_wd;
  logic [WE_W-1:0]    ex_wreg;
  logic [DATA_W-1:0]  ex_wdata;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [DATA_W-1:0]  ex_mem_addr;
  logic [DATA_W-1:0]  ex_reg2;
  logic [DATA_W-1:0]  ex_pc;
  logic               out_valid;
  logic               out_ready;
  logic [RADDR_W-1:0] mem_wd;
  logic [WE_W-1:0]    mem_wreg;
  logic [DATA_W-1:0]  mem_wdata;
  logic [ALUOP_W-1:0] mem_aluop;
  logic [DATA_W-1:0]  mem_mem_addr;
  logic [DATA_W-1:0]  mem_reg2;
  logic [DATA_W-1:0]  mem_pc;
  logic [1:0]         occupancy;
  logic               fwd_valid;
  logic [RADDR_W-1:0] fwd_wd;
  logic [WE_W-1:0]    fwd_wreg;
  logic [DATA_W-1:0]  fwd_wdata;

  modport slave (
    input  flush, in_valid, ex_wd, ex_wreg, ex_wdata, ex_aluop, ex_mem_addr,
           ex_reg2, ex_pc, out_ready,
    output in_ready, out_valid, mem_wd, mem_wreg, mem_wdata, mem_aluop,
           mem_mem_addr, mem_reg2, mem_pc, occupancy, fwd_valid, fwd_wd,
           fwd_wreg, fwd_wdata
  );

  modport master (
    output flush, in_valid, ex_wd, ex_wreg, ex_wdata, ex_aluop, ex_mem_addr,
           ex_reg2, ex_pc, out_ready,
    input  in_ready, out_valid, mem_wd, mem_wreg, mem_wdata, mem_aluop,
           mem_mem_addr, mem_reg2, mem_pc, occupancy, fwd_valid, fwd_wd,
           fwd_wreg, fwd_wdata
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: two-entry (head + skid) EX/MEM pipeline register with
// valid/ready handshakes, flush, bubble zeroing and an ID-stage forwarding
// tap.
// Ports:
//   clk : clock. All state updates on the rising edge.
//   rst : synchronous active-high reset. It has priority over flush and
//         over all handshakes.
//   bus : ex_mem_pipe_if.slave. It carries the EX payload and handshake,
//         the MEM payload and handshake, occupancy, and fwd_*.
// Every output is registered. in_ready depends only on state, so there is
// no combinational path from out_ready to in_ready.
module ex_mem_pipe #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int WE_W    = 4,
  parameter int ALUOP_W = 8
) (
  input logic clk,
  input logic rst,
  ex_mem_pipe_if.slave bus
);

  typedef struct packed {
    logic [RADDR_W-1:0] wd;
    logic [WE_W-1:0]    wreg;
    logic [DATA_W-1:0]  wdata;
    logic [ALUOP_W-1:0] aluop;
    logic [DATA_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  reg2;
    logic [DATA_W-1:0]  pc;
  } payload_t;

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  payload_t           head_q, head_d;
  payload_t           skid_q, skid_d;
  payload_t           mem_q, mem_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               fwd_valid_q, fwd_valid_d;
  logic [RADDR_W-1:0] fwd_wd_q, fwd_wd_d;
  logic [WE_W-1:0]    fwd_wreg_q, fwd_wreg_d;
  logic [DATA_W-1:0]  fwd_wdata_q, fwd_wdata_d;
  payload_t           in_pay_s;
  logic               push_s;
  logic               pop_s;

  // Next state, entry loads and the next values of the registered outputs.
  always_comb begin
    in_pay_s = '{wd: bus.ex_wd, wreg: bus.ex_wreg, wdata: bus.ex_wdata,
                 aluop: bus.ex_aluop, mem_addr: bus.ex_mem_addr,
                 reg2: bus.ex_reg2, pc: bus.ex_pc};
    push_s   = bus.in_valid & in_ready_q;
    pop_s    = out_valid_q & bus.out_ready;
    state_d  = state_q;
    head_d   = head_q;
    skid_d   = skid_q;

    if (bus.flush) begin
      // A flush drops every entry, including any beat that arrives with it.
      // The payload registers keep their values. Only the state changes.
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push_s) begin
            state_d = S_ONE;
            head_d  = in_pay_s;
          end else begin
            state_d = S_EMPTY;
          end
        end
        S_ONE: begin
          if (push_s && !pop_s) begin
            state_d = S_FULL;
            skid_d  = in_pay_s;
          end else if (!push_s && pop_s) begin
            state_d = S_EMPTY;
          end else if (push_s && pop_s) begin
            // Streaming case: the new beat replaces the departing head.
            state_d = S_ONE;
            head_d  = in_pay_s;
          end else begin
            state_d = S_ONE;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop_s) begin
            state_d = S_ONE;
            head_d  = skid_q;
          end else begin
            state_d = S_FULL;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end

    in_ready_d  = (state_d != S_FULL);
    out_valid_d = (state_d != S_EMPTY);
    // A bubble presents an all-zero payload, so it acts as a NOP with no
    // register write.
    mem_d       = out_valid_d ? head_d : '0;

    // The forwarding tap shows the youngest held entry.
    case (state_d)
      S_FULL: begin
        fwd_valid_d = 1'b1;
        fwd_wd_d    = skid_d.wd;
        fwd_wreg_d  = skid_d.wreg;
        fwd_wdata_d = skid_d.wdata;
      end
      S_ONE: begin
        fwd_valid_d = 1'b1;
        fwd_wd_d    = head_d.wd;
        fwd_wreg_d  = head_d.wreg;
        fwd_wdata_d = head_d.wdata;
      end
      default: begin
        fwd_valid_d = 1'b0;
        fwd_wd_d    = '0;
        fwd_wreg_d  = '0;
        fwd_wdata_d = '0;
      end
    endcase
  end

  // State, entries and registered outputs. Reset has priority over all else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      mem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_wd_q    <= '0;
      fwd_wreg_q  <= '0;
      fwd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      mem_q       <= mem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_wd_q    <= fwd_wd_d;
      fwd_wreg_q  <= fwd_wreg_d;
      fwd_wdata_q <= fwd_wdata_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.occupancy    = state_q;
  assign bus.mem_wd       = mem_q.wd;
  assign bus.mem_wreg     = mem_q.wreg;
  assign bus.mem_wdata    = mem_q.wdata;
  assign bus.mem_aluop    = mem_q.aluop;
  assign bus.mem_mem_addr = mem_q.mem_addr;
  assign bus.mem_reg2     = mem_q.reg2;
  assign bus.mem_pc       = mem_q.pc;
  assign bus.fwd_valid    = fwd_valid_q;
  assign bus.fwd_wd       = fwd_wd_q;
  assign bus.fwd_wreg     = fwd_wreg_q;
  assign bus.fwd_wdata    = fwd_wdata_q;

endmodule
